// File: rtl/reaction_timer_core.sv
// Reaction tester core: random hold-off, GO lamp and response timing in ticks.
// Also detects false starts and timeouts and keeps the best valid time.
module reaction_timer_core #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int MAX_COUNT    = 999,
  parameter int CNT_W        = 10,
  parameter int NUM_PLAYERS  = 2,
  parameter int PID_W        = 1,
  parameter int DELAY_MIN    = 1000,
  parameter int DELAY_RAND_W = 11
) (
  input  logic                   clk_50M,
  input  logic                   clear,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] stop,
  output logic                   go_led,
  output logic                   running,
  output logic [CNT_W-1:0]       time_ms,
  output logic [PID_W-1:0]       winner,
  output logic                   foul,
  output logic                   timeout,
  output logic [CNT_W-1:0]       best_ms,
  output logic                   best_valid
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DLY_W = $clog2(DELAY_MIN + 2**DELAY_RAND_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_GO, S_DONE, S_FOUL, S_TOUT
  } state_t;

  state_t                 state_q, state_d;
  logic                   start_r_q, start_p_q;
  logic [NUM_PLAYERS-1:0] stop_r_q, stop_p_q;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic [CNT_W-1:0]       time_q, time_d, best_q, best_d;
  logic [PID_W-1:0]       winner_q, winner_d;
  logic                   foul_q, foul_d, tout_q, tout_d, bv_q, bv_d;
  logic                   go_q, go_d, run_q, run_d;
  logic                   start_edge, tick;
  logic [NUM_PLAYERS-1:0] stop_edge;

  function automatic logic [PID_W-1:0] lowest(input logic [NUM_PLAYERS-1:0] v);
    logic [PID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_PLAYERS-1; i >= 0; i--)
      if (v[i]) idx = PID_W'(i);
    return idx;
  endfunction

  // Edges come from the registered copy only, so a held level never retriggers.
  assign start_edge = start_r_q & ~start_p_q;
  assign stop_edge  = stop_r_q & ~stop_p_q;
  assign tick       = (pre_q == PRE_W'(DIV-1));
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d  = state_q;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    dly_d    = dly_q;
    time_d   = time_q;
    winner_d = winner_q;
    foul_d   = foul_q;
    tout_d   = tout_q;
    best_d   = best_q;
    bv_d     = bv_q;
    case (state_q)
      S_WAIT: begin
        if (|stop_edge) begin
          state_d  = S_FOUL;
          foul_d   = 1'b1;
          winner_d = lowest(stop_edge);
        end else if (tick) begin
          if (dly_q == DLY_W'(1)) begin
            state_d = S_GO;
            pre_d   = '0;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      S_GO: begin
        // A stop edge beats a coincident tick so the frozen time is not bumped.
        if (|stop_edge) begin
          state_d  = S_DONE;
          winner_d = lowest(stop_edge);
          if (!bv_q || time_q < best_q) begin
            best_d = time_q;
            bv_d   = 1'b1;
          end
        end else if (tick) begin
          if (time_q == CNT_W'(MAX_COUNT-1)) begin
            state_d = S_TOUT;
            time_d  = CNT_W'(MAX_COUNT);
            tout_d  = 1'b1;
          end else begin
            time_d = time_q + 1'b1;
          end
        end
      end
      default: begin
        if (start_edge) begin
          state_d  = S_WAIT;
          pre_d    = '0;
          dly_d    = DLY_W'(DELAY_MIN) + DLY_W'(lfsr_q[DELAY_RAND_W-1:0]);
          time_d   = '0;
          winner_d = '0;
          foul_d   = 1'b0;
          tout_d   = 1'b0;
        end
      end
    endcase
    go_d  = (state_d == S_GO);
    run_d = (state_d == S_WAIT) || (state_d == S_GO);
  end

  always_ff @(posedge clk_50M or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      start_r_q <= 1'b0;
      start_p_q <= 1'b0;
      stop_r_q  <= '0;
      stop_p_q  <= '0;
      lfsr_q    <= 16'hACE1;
      pre_q     <= '0;
      dly_q     <= '0;
      time_q    <= '0;
      winner_q  <= '0;
      foul_q    <= 1'b0;
      tout_q    <= 1'b0;
      best_q    <= '0;
      bv_q      <= 1'b0;
      go_q      <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_r_q <= start;
      start_p_q <= start_r_q;
      stop_r_q  <= stop;
      stop_p_q  <= stop_r_q;
      lfsr_q    <= lfsr_d;
      pre_q     <= pre_d;
      dly_q     <= dly_d;
      time_q    <= time_d;
      winner_q  <= winner_d;
      foul_q    <= foul_d;
      tout_q    <= tout_d;
      best_q    <= best_d;
      bv_q      <= bv_d;
      go_q      <= go_d;
      run_q     <= run_d;
    end
  end

  assign go_led     = go_q;
  assign running    = run_q;
  assign time_ms    = time_q;
  assign winner     = winner_q;
  assign foul       = foul_q;
  assign timeout    = tout_q;
  assign best_ms    = best_q;
  assign best_valid = bv_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: expected results queued when stop/start is
// driven, then compared once the DUT leaves WAIT/GO.
module tb_reaction_timer_core;

  logic       clk_50M = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [3:0] stop = 4'b0;
  logic       go_led, running, foul, timeout, best_valid;
  logic [5:0] time_ms, best_ms;
  logic [1:0] winner;

  typedef struct {
    logic [5:0] t;
    logic [1:0] w;
    logic       f;
    logic       to;
    logic [5:0] b;
    logic       bv;
  } exp_t;

  exp_t exp_q[$];
  int   nasrt = 0;
  int   nfail = 0;
  logic [5:0] best_m = '0;
  logic       bv_m = 1'b0;

  reaction_timer_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .MAX_COUNT(50), .CNT_W(6),
    .NUM_PLAYERS(4), .PID_W(2), .DELAY_MIN(5), .DELAY_RAND_W(3)
  ) dut (
    .clk_50M(clk_50M), .clear(clear), .start(start), .stop(stop),
    .go_led(go_led), .running(running), .time_ms(time_ms), .winner(winner),
    .foul(foul), .timeout(timeout), .best_ms(best_ms), .best_valid(best_valid)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic exp_t observe();
    exp_t o;
    o.t = time_ms; o.w = winner; o.f = foul; o.to = timeout;
    o.b = best_ms; o.bv = best_valid;
    return o;
  endfunction

  function automatic exp_t mk_done(input logic [5:0] t, input logic [1:0] w);
    exp_t e;
    if (!bv_m || t < best_m) begin
      best_m = t;
      bv_m   = 1'b1;
    end
    e.t = t; e.w = w; e.f = 1'b0; e.to = 1'b0; e.b = best_m; e.bv = bv_m;
    return e;
  endfunction

  // Start pulse, then wait for GO; k = posedges from the start drive to go_led.
  task automatic start_wait_go(output int k, output bit seen);
    @(posedge clk_50M); #1 start = 1'b1;
    k = 0; seen = 1'b0;
    while (k < 300 && !seen) begin
      @(posedge clk_50M); #1 k++;
      if (k == 2) start = 1'b0;
      if (go_led) seen = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk_50M); #1;
      if (!running) ok = 1'b1;
    end
  endtask

  task automatic run_once(input string nm, input logic [3:0] mask, input int cyc,
                          input logic [5:0] t_exp, input logic [1:0] w_exp);
    int k; bit seen, ok; exp_t e, o;
    start_wait_go(k, seen);
    nasrt++;
    if (!seen || (k - 2) % 10 != 0 || (k - 2) / 10 < 5 || (k - 2) / 10 > 12) begin
      nfail++;
      $display("FAIL %s wait_len: got %0d cycles (seen=%0d), required 2+10*n, n in 5..12", nm, k, seen);
    end
    repeat (cyc) @(posedge clk_50M);
    #1 stop = mask;
    exp_q.push_back(mk_done(t_exp, w_exp));
    wait_idle(ok);
    stop = 4'b0;
    nasrt++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s idle_timeout: running still high", nm);
    end
    e = exp_q.pop_front();
    o = observe();
    nasrt++;
    if (o !== e || go_led !== 1'b0) begin
      nfail++;
      $display("FAIL %s result: got t=%0d w=%0d f=%0d to=%0d b=%0d bv=%0d go=%0d, required t=%0d w=%0d f=%0d to=%0d b=%0d bv=%0d go=0",
               nm, o.t, o.w, o.f, o.to, o.b, o.bv, go_led, e.t, e.w, e.f, e.to, e.b, e.bv);
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    best_m = '0; bv_m = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1 clear = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] v;
    clear = 1'b0;
    repeat (2) @(posedge clk_50M);
    #1 v = {go_led, running, time_ms, winner, foul, timeout, best_ms, best_valid};
    nasrt++;
    if (v !== 23'b0) begin
      nfail++;
      $display("FAIL reset_outputs: got %h, required 0", v);
    end
    clear = 1'b1;
    repeat (5) @(posedge clk_50M);
    #1 nasrt++;
    if (running !== 1'b0 || go_led !== 1'b0) begin
      nfail++;
      $display("FAIL idle_after_reset: got running=%0d go=%0d, required 0 0", running, go_led);
    end
  endtask

  task automatic test_done();
    run_once("done_p2", 4'b0100, 70, 6'd7, 2'd2);
  endtask

  task automatic test_foul();
    bit go_seen, ok; exp_t e, o;
    go_seen = 1'b0;
    @(posedge clk_50M); #1 start = 1'b1;
    repeat (2) @(posedge clk_50M);
    #1 start = 1'b0;
    repeat (20) begin
      @(posedge clk_50M); #1;
      if (go_led) go_seen = 1'b1;
    end
    stop = 4'b0010;
    e.t = '0; e.w = 2'd1; e.f = 1'b1; e.to = 1'b0; e.b = best_m; e.bv = bv_m;
    exp_q.push_back(e);
    wait_idle(ok);
    repeat (150) begin
      @(posedge clk_50M); #1;
      if (go_led) go_seen = 1'b1;
    end
    stop = 4'b0;
    nasrt++;
    if (!ok || go_seen) begin
      nfail++;
      $display("FAIL foul_go_lamp: got idle_ok=%0d go_seen=%0d, required 1 0", ok, go_seen);
    end
    e = exp_q.pop_front();
    o = observe();
    nasrt++;
    if (o !== e) begin
      nfail++;
      $display("FAIL foul_result: got t=%0d w=%0d f=%0d to=%0d b=%0d bv=%0d, required t=%0d w=%0d f=%0d to=%0d b=%0d bv=%0d",
               o.t, o.w, o.f, o.to, o.b, o.bv, e.t, e.w, e.f, e.to, e.b, e.bv);
    end
  endtask

  task automatic test_timeout();
    int k, c; bit seen; exp_t e, o;
    start_wait_go(k, seen);
    e.t = 6'd50; e.w = '0; e.f = 1'b0; e.to = 1'b1; e.b = best_m; e.bv = bv_m;
    exp_q.push_back(e);
    c = 0;
    while (c < 700 && go_led) begin
      @(posedge clk_50M); #1 c++;
    end
    nasrt++;
    if (!seen || c != 500) begin
      nfail++;
      $display("FAIL timeout_len: got %0d cycles (seen=%0d), required 500", c, seen);
    end
    e = exp_q.pop_front();
    o = observe();
    nasrt++;
    if (o !== e || running !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_result: got t=%0d w=%0d f=%0d to=%0d b=%0d bv=%0d run=%0d, required t=%0d w=%0d f=%0d to=%0d b=%0d bv=%0d run=0",
               o.t, o.w, o.f, o.to, o.b, o.bv, running, e.t, e.w, e.f, e.to, e.b, e.bv);
    end
  endtask

  // Stop edge lands in the cycle whose tick would take time_ms from 6 to 7.
  task automatic test_tie_tick();
    run_once("tie_tick", 4'b1001, 68, 6'd6, 2'd0);
  endtask

  task automatic test_best();
    do_reset();
    run_once("best_12", 4'b0001, 120, 6'd12, 2'd0);
    run_once("best_9", 4'b0010, 90, 6'd9, 2'd1);
    run_once("best_20", 4'b1000, 200, 6'd20, 2'd3);
  endtask

  task automatic test_async_clear();
    int k; bit seen; logic [22:0] v;
    start_wait_go(k, seen);
    repeat (15) @(posedge clk_50M);
    #3 clear = 1'b0;
    best_m = '0; bv_m = 1'b0;
    #1 v = {go_led, running, time_ms, winner, foul, timeout, best_ms, best_valid};
    nasrt++;
    if (!seen || v !== 23'b0) begin
      nfail++;
      $display("FAIL async_clear: got %h (seen=%0d), required 0", v, seen);
    end
    stop = 4'b0010;
    @(posedge clk_50M); #1 clear = 1'b1;
    repeat (5) @(posedge clk_50M);
    #1 start = 1'b1;
    repeat (2) @(posedge clk_50M);
    #1 start = 1'b0;
    repeat (30) @(posedge clk_50M);
    #1 nasrt++;
    if (foul !== 1'b0 || running !== 1'b1) begin
      nfail++;
      $display("FAIL held_stop: got foul=%0d running=%0d, required 0 1", foul, running);
    end
    stop = 4'b0;
    wait_idle(seen);
    run_once("after_clear", 4'b1000, 30, 6'd3, 2'd3);
  endtask

  initial begin
    test_reset();
    test_done();
    test_foul();
    test_timeout();
    test_tie_tick();
    test_best();
    test_async_clear();
    nasrt++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
